ball_sequencer: RTL

- Sits between the bottom of the cell fabric and the board's `blue_trigger`/`red_trigger` inputs.
- Turns a start-lever press and ball-exit events (left lane, right lane, interceptor) into clean registered trigger pulses.
- Enforces one ball in flight at a time and detects stalls and faults.
- Reports why the machine stopped.

---
 rtl/tumble_pkg.sv | 8 +
 rtl/tumble_watchdog.sv | 22 ++
 rtl/ball_sequencer.sv | 115 +++++++++++
 3 files changed

// File: rtl/tumble_pkg.sv
// tumble_pkg: shared colour constants, FSM state and halt-reason encodings
//   BLUE/RED match the board's trigger colour encoding.
package tumble_pkg;
    localparam logic BLUE = 1'b0;
    localparam logic RED  = 1'b1;
    typedef enum logic [1:0] {IDLE, TRIG, FLIGHT, HALT} state_t;
    typedef enum logic [1:0] {NONE, INTERCEPT, EMPTY, FAULT} reason_t;
endpackage

// File: rtl/tumble_watchdog.sv
// tumble_watchdog: FLIGHT stall detector (down-counter)
//   clk, rst : clock, synchronous active-high reset
//   load     : reload the count to TIMEOUT-1 (held while not in FLIGHT)
//   run      : count down one per cycle
//   expired  : high in the TIMEOUT-th running cycle
module tumble_watchdog #(
    parameter int W       = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expired
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst || load) cnt <= W'(TIMEOUT - 1);
        else if (run && cnt != '0) cnt <= cnt - 1'b1;
    end
    assign expired = run && cnt == '0;
endmodule

// File: rtl/ball_sequencer.sv
// ball_sequencer: turns start/exit events into registered blue/red trigger pulses
//   Inputs : clk, rst, start, start_color, exit_left, exit_right, intercept,
//            no_balls, clear
//   Outputs: blue_trigger, red_trigger (flopped pulses), busy, halted,
//            halt_reason, launched (saturating launch count)
//   Macro BALL_SEQUENCER_WATCHDOG_EN builds the FLIGHT stall watchdog.
module ball_sequencer
    import tumble_pkg::*;
#(
    parameter int PULSE_LEN = 2,
    parameter int TIMEOUT   = 1000,
    parameter int COUNT_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               start_color,
    input  logic               exit_left,
    input  logic               exit_right,
    input  logic               intercept,
    input  logic               no_balls,
    input  logic               clear,
    output logic               blue_trigger,
    output logic               red_trigger,
    output logic               busy,
    output logic               halted,
    output logic [1:0]         halt_reason,
    output logic [COUNT_W-1:0] launched
);
    state_t     state, nxt;
    reason_t    reason, nxt_reason;
    logic       color, nxt_color;
    logic [3:0] cnt;
    logic       first;
    logic       wd_expired;

`ifdef BALL_SEQUENCER_WATCHDOG_EN
    tumble_watchdog #(.W(16), .TIMEOUT(TIMEOUT)) u_wd (
        .clk     (clk),
        .rst     (rst),
        .load    (state != FLIGHT),
        .run     (state == FLIGHT),
        .expired (wd_expired)
    );
`else
    // TIMEOUT is always >= 2, so expiry is tied low without a watchdog
    assign wd_expired = (TIMEOUT == 0);
`endif

    always_comb begin
        nxt        = state;
        nxt_color  = color;
        nxt_reason = reason;
        case (state)
            IDLE: if (start) begin
                nxt       = TRIG;
                nxt_color = start_color;
            end
            TRIG: if (cnt == 4'(PULSE_LEN - 1)) nxt = FLIGHT;
            FLIGHT: begin
                if (first && no_balls) begin
                    nxt        = HALT;
                    nxt_reason = EMPTY;
                end else if (intercept) begin
                    nxt        = HALT;
                    nxt_reason = INTERCEPT;
                end else if (exit_left && exit_right) begin
                    nxt        = HALT;
                    nxt_reason = FAULT;
                end else if (exit_left) begin
                    nxt       = TRIG;
                    nxt_color = BLUE;
                end else if (exit_right) begin
                    nxt       = TRIG;
                    nxt_color = RED;
                end else if (wd_expired) begin
                    nxt        = HALT;
                    nxt_reason = FAULT;
                end
            end
            HALT: if (clear) begin
                nxt        = IDLE;
                nxt_reason = NONE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Triggers are decoded from the next state so they rise on the same edge TRIG is entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            reason       <= NONE;
            color        <= BLUE;
            cnt          <= '0;
            first        <= 1'b0;
            blue_trigger <= 1'b0;
            red_trigger  <= 1'b0;
            launched     <= '0;
        end else begin
            state        <= nxt;
            reason       <= nxt_reason;
            color        <= nxt_color;
            cnt          <= (state == TRIG && nxt == TRIG) ? cnt + 4'd1 : 4'd0;
            first        <= state == TRIG && nxt == FLIGHT;
            blue_trigger <= nxt == TRIG && nxt_color == BLUE;
            red_trigger  <= nxt == TRIG && nxt_color == RED;
            if (nxt == TRIG && state != TRIG && launched != '1) launched <= launched + 1'b1;
        end
    end

    assign busy        = state == TRIG || state == FLIGHT;
    assign halted      = state == HALT;
    assign halt_reason = reason;
endmodule
